// File: rtl/router_pkt_ctrl.sv
// Router packet controller: parses header/payload/parity bytes from a single
// source, steers them into one of three destination FIFOs, checks packet
// parity, and soft-resets any FIFO whose reader stops draining it.
module router_pkt_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    PARITY,
    DROP,
    CHECK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  addr_q;
  logic [5:0]  len_q;
  logic [5:0]  count;
  logic [7:0]  parity_acc;
  logic [6:0]  drop_left;
  logic        accept;
  logic        abort;
  logic [1:0]  hdr_addr;
  logic [5:0]  hdr_len;
  logic [2:0]  hdr_sel;
  logic [2:0]  dest_sel;
  logic        dest_full;
  logic        soft_hit;
  logic [CW-1:0] to_cnt [3];

  // Address 3 maps to no FIFO, so it decodes to an all-zero select.
  function automatic logic [2:0] addr_onehot(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign hdr_addr  = data_in[1:0];
  assign hdr_len   = data_in[7:2];
  assign hdr_sel   = addr_onehot(hdr_addr);
  assign dest_sel  = addr_onehot(addr_q);
  assign dest_full = |(fifo_full & dest_sel);
  assign soft_hit  = |(soft_reset & dest_sel);
  assign vld_out   = ~fifo_empty;

  // Next-state and handshake decode; reset forces every strobe low.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    write_enb  = 3'b000;
    lfd_state  = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            if (hdr_addr == 2'd3) begin
              accept     = 1'b1;
              state_next = DROP;
            end else if (|(fifo_full & hdr_sel)) begin
              busy = 1'b1;
            end else begin
              accept     = 1'b1;
              write_enb  = hdr_sel;
              lfd_state  = 1'b1;
              state_next = (hdr_len == 6'd0) ? PARITY : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (soft_hit) begin
            busy       = 1'b1;
            abort      = 1'b1;
            state_next = DROP;
          end else begin
            busy = dest_full;
            if (pkt_valid && !dest_full) begin
              accept    = 1'b1;
              write_enb = dest_sel;
              if (count + 6'd1 == len_q) state_next = PARITY;
            end
          end
        end
        PARITY: begin
          if (soft_hit) begin
            busy       = 1'b1;
            abort      = 1'b1;
            state_next = DROP;
          end else begin
            busy = dest_full;
            if (pkt_valid && !dest_full) begin
              accept     = 1'b1;
              write_enb  = dest_sel;
              state_next = CHECK;
            end
          end
        end
        CHECK: begin
          busy       = 1'b1;
          state_next = IDLE;
        end
        DROP: begin
          if (pkt_valid) begin
            accept = 1'b1;
            if (drop_left == 7'd1) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Packet state, byte counters and running parity; the parity byte itself
  // is folded into the accumulator so a good packet leaves it at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= 2'd0;
      len_q      <= 6'd0;
      count      <= 6'd0;
      parity_acc <= 8'd0;
      drop_left  <= 7'd0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= hdr_addr;
            len_q      <= hdr_len;
            count      <= 6'd0;
            parity_acc <= data_in;
            drop_left  <= {1'b0, hdr_len} + 7'd1;
          end
        end
        PAYLOAD: begin
          if (abort) begin
            drop_left <= {1'b0, len_q - count} + 7'd1;
          end else if (accept) begin
            count      <= count + 6'd1;
            parity_acc <= parity_acc ^ data_in;
          end
        end
        PARITY: begin
          if (abort) begin
            drop_left <= 7'd1;
          end else if (accept) begin
            parity_acc <= parity_acc ^ data_in;
          end
        end
        CHECK: begin
          err        <= |parity_acc;
          parity_acc <= 8'd0;
          count      <= 6'd0;
        end
        DROP: begin
          if (accept) drop_left <= drop_left - 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Per-output stall watchdog: the pulse lands in the TIMEOUT-th stalled cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        to_cnt[i]     <= '0;
        soft_reset[i] <= 1'b0;
      end else if (fifo_empty[i] || read_enb[i]) begin
        to_cnt[i]     <= '0;
        soft_reset[i] <= 1'b0;
      end else if (to_cnt[i] == CW'(TIMEOUT - 2)) begin
        to_cnt[i]     <= '0;
        soft_reset[i] <= 1'b1;
      end else begin
        to_cnt[i]     <= to_cnt[i] + CW'(1);
        soft_reset[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed testbench for router_pkt_ctrl: hand-built packets with
// precomputed parity, flow-control stalls, address-3 drops, watchdog
// timeouts, watchdog-driven packet abort and mid-packet reset.
module tb_router_pkt_ctrl;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       err;

  int vectors;
  int miscompares;
  int wr_count;

  router_pkt_ctrl #(.TIMEOUT(30)) dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .busy       (busy),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .vld_out    (vld_out),
    .soft_reset (soft_reset),
    .err        (err)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs just after a rising edge, then park on the
  // falling edge so outputs can be sampled; FIFO-1 writes are tallied here.
  task automatic applyStimulus(input logic rst, input logic pv, input logic [7:0] d,
                               input logic [2:0] full, input logic [2:0] empty,
                               input logic [2:0] rd);
    @(posedge clock);
    #1;
    reset      = rst;
    pkt_valid  = pv;
    data_in    = d;
    fifo_full  = full;
    fifo_empty = empty;
    read_enb   = rd;
    @(negedge clock);
    if (write_enb[1]) wr_count++;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    wr_count = 0;
  endtask

  // Present one accepted-or-refused byte and check the handshake strobes.
  task automatic sendByte(input string tag, input logic [7:0] d, input logic [2:0] full,
                          input logic [2:0] exp_we, input logic exp_lfd,
                          input logic exp_busy);
    applyStimulus(1'b0, 1'b1, d, full, 3'b111, 3'b000);
    checkOutput({tag, "_we"}, {5'd0, write_enb}, {5'd0, exp_we});
    checkOutput({tag, "_lfd"}, {7'd0, lfd_state}, {7'd0, exp_lfd});
    checkOutput({tag, "_busy"}, {7'd0, busy}, {7'd0, exp_busy});
  endtask

  // Two idle cycles after a parity byte: CHECK (busy, no err yet), then err.
  task automatic checkParityResult(input string tag, input logic exp_err);
    applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    checkOutput({tag, "_chk_busy"}, {7'd0, busy}, 8'd1);
    checkOutput({tag, "_chk_err"}, {7'd0, err}, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    checkOutput({tag, "_err"}, {7'd0, err}, {7'd0, exp_err});
    applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    checkOutput({tag, "_err_clr"}, {7'd0, err}, 8'd0);
  endtask

  // Payload 11 A5 3C 0F F0 gives XOR parity 77.
  logic [7:0] payload [4];
  bit         seen;

  initial begin
    vectors     = 0;
    miscompares = 0;
    wr_count    = 0;
    reset       = 1'b1;
    pkt_valid   = 1'b0;
    data_in     = 8'h00;
    fifo_full   = 3'b000;
    fifo_empty  = 3'b111;
    read_enb    = 3'b000;
    payload[0] = 8'hA5; payload[1] = 8'h3C; payload[2] = 8'h0F; payload[3] = 8'hF0;

    // Strobes are gated while reset is held; registered outputs are cleared.
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h11, 3'b000, 3'b111, 3'b000);
    checkOutput("rst_we", {5'd0, write_enb}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_lfd", {7'd0, lfd_state}, 8'd0);
    checkOutput("rst_err", {7'd0, err}, 8'd0);
    checkOutput("rst_soft", {5'd0, soft_reset}, 8'h00);
    checkOutput("rst_vld", {5'd0, vld_out}, 8'h00);

    // Good packet to FIFO 1.
    doReset();
    sendByte("good_hdr", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sendByte("good_pl", payload[i], 3'b000, 3'b010, 1'b0, 1'b0);
    sendByte("good_par", 8'h77, 3'b000, 3'b010, 1'b0, 1'b0);
    checkParityResult("good", 1'b0);
    checkOutput("good_writes", 8'(wr_count), 8'd6);

    // Same packet, corrupted parity byte.
    doReset();
    sendByte("bad_hdr", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sendByte("bad_pl", payload[i], 3'b000, 3'b010, 1'b0, 1'b0);
    sendByte("bad_par", 8'h78, 3'b000, 3'b010, 1'b0, 1'b0);
    checkParityResult("bad", 1'b1);
    checkOutput("bad_writes", 8'(wr_count), 8'd6);

    // Full FIFO refuses the header, then stalls the payload for 3 cycles.
    doReset();
    sendByte("full_hdr_blk", 8'h11, 3'b010, 3'b000, 1'b0, 1'b1);
    sendByte("full_hdr", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    sendByte("full_pl0", payload[0], 3'b000, 3'b010, 1'b0, 1'b0);
    sendByte("full_pl1", payload[1], 3'b000, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sendByte("full_stall", payload[2], 3'b010, 3'b000, 1'b0, 1'b1);
    sendByte("full_other", payload[2], 3'b101, 3'b010, 1'b0, 1'b0);
    sendByte("full_pl3", payload[3], 3'b000, 3'b010, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    checkOutput("full_gap_we", {5'd0, write_enb}, 8'h00);
    sendByte("full_par", 8'h77, 3'b000, 3'b010, 1'b0, 1'b0);
    checkParityResult("full", 1'b0);
    checkOutput("full_writes", 8'(wr_count), 8'd6);

    // Zero-length packet to FIFO 2: header then parity straight away.
    doReset();
    sendByte("len0_hdr", 8'h02, 3'b000, 3'b100, 1'b1, 1'b0);
    sendByte("len0_par", 8'h02, 3'b000, 3'b100, 1'b0, 1'b0);
    checkParityResult("len0", 1'b0);

    // Address 3 packet is swallowed without any write.
    doReset();
    sendByte("drop_hdr", 8'h0B, 3'b000, 3'b000, 1'b0, 1'b0);
    sendByte("drop_b0", 8'h55, 3'b111, 3'b000, 1'b0, 1'b0);
    sendByte("drop_b1", 8'hAA, 3'b000, 3'b000, 1'b0, 1'b0);
    sendByte("drop_b2", 8'h13, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("drop_err", {7'd0, err}, 8'd0);
    sendByte("drop_next", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    checkOutput("drop_err2", {7'd0, err}, 8'd0);

    // FIFO 0 stalled: pulse exactly on the 30th stalled cycle.
    doReset();
    for (int k = 1; k <= 31; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
      checkOutput($sformatf("to0_c%0d", k), {5'd0, soft_reset},
                  (k == 30) ? 8'h01 : 8'h00);
    end
    checkOutput("to0_vld", {5'd0, vld_out}, 8'h01);

    // A read at cycle 20 restarts the watchdog, so no pulse through cycle 45.
    doReset();
    for (int k = 1; k <= 45; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b110, (k == 20) ? 3'b001 : 3'b000);
      checkOutput($sformatf("to0rd_c%0d", k), {5'd0, soft_reset}, 8'h00);
    end

    // All three outputs stalled together time out together.
    doReset();
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 3'b000);
      if (k >= 29) checkOutput($sformatf("to_all_c%0d", k), {5'd0, soft_reset},
                               (k == 30) ? 8'h07 : 8'h00);
    end

    // Watchdog fires on FIFO 1 mid-packet: the rest of the packet is dropped.
    doReset();
    sendByte("ab_hdr", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    sendByte("ab_pl0", payload[0], 3'b000, 3'b010, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 3'b000, 3'b101, 3'b000);
      if (soft_reset[1]) begin
        seen = 1'b1;
        checkOutput("ab_cycle", 8'(k), 8'd30);
        checkOutput("ab_busy", {7'd0, busy}, 8'd1);
        checkOutput("ab_we", {5'd0, write_enb}, 8'h00);
      end
    end
    checkOutput("ab_seen", {7'd0, seen}, 8'd1);
    for (int i = 1; i < 4; i++) sendByte("ab_drop_pl", payload[i], 3'b000, 3'b000, 1'b0, 1'b0);
    sendByte("ab_drop_par", 8'h77, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("ab_err", {7'd0, err}, 8'd0);
    sendByte("ab_next", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    checkOutput("ab_err2", {7'd0, err}, 8'd0);

    // Reset during payload byte 2 of a FIFO-2 packet, then a fresh header.
    doReset();
    sendByte("mr_hdr", 8'h12, 3'b000, 3'b100, 1'b1, 1'b0);
    sendByte("mr_pl0", payload[0], 3'b000, 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, payload[1], 3'b000, 3'b111, 3'b000);
    checkOutput("mr_rst_we", {5'd0, write_enb}, 8'h00);
    checkOutput("mr_rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("mr_rst_lfd", {7'd0, lfd_state}, 8'd0);
    sendByte("mr_new", 8'h11, 3'b000, 3'b010, 1'b1, 1'b0);
    checkOutput("mr_err", {7'd0, err}, 8'd0);
    checkOutput("mr_soft", {5'd0, soft_reset}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_pkt_ctrl.md
ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, cycles a non-empty FIFO may go unread before its soft reset.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port pkt_valid  in  1  source byte on data_in is valid.
REQ-005 SHALL have port data_in  in  8  packet byte; header = {payload_len[5:0], addr[1:0]}, then payload_len payload bytes, then 1 parity byte.
REQ-006 SHALL have port fifo_full  in  3  full flag of router_fifo 0..2.
REQ-007 SHALL have port fifo_empty  in  3  empty flag of router_fifo 0..2.
REQ-008 SHALL have port read_enb  in  3  read strobe of destination 0..2.
REQ-009 SHALL have port busy  out  1  byte on data_in not accepted this cycle; source holds it.
REQ-010 SHALL have port write_enb  out  3  one-hot FIFO write strobe; FIFO captures data_in on the same edge.
REQ-011 SHALL have port lfd_state  out  1  byte being written is a header.
REQ-012 SHALL have port vld_out  out  3  vld_out[i] = ~fifo_empty[i].
REQ-013 SHALL have port soft_reset  out  3  one-cycle registered soft reset of FIFO i.
REQ-014 SHALL have port err  out  1  one-cycle registered parity-error pulse.

Function
REQ-015 SHALL accept a byte when pkt_valid=1 and busy=0 (accept); nothing else advances the packet FSM.
REQ-016 SHALL implement FSM states IDLE, PAYLOAD, PARITY, DROP, CHECK.
REQ-017 IDLE: header with addr in 0..2 and fifo_full[addr]=0 -> accept, latch addr/len, write_enb[addr]=1, lfd_state=1, next PAYLOAD (PARITY if len=0).
REQ-018 IDLE: header with addr in 0..2 and fifo_full[addr]=1 -> busy=1, no write, stay IDLE.
REQ-019 IDLE: header with addr=3 -> accept, no write, next DROP with len+1 bytes to discard.
REQ-020 PAYLOAD: busy = fifo_full[addr]; each accept asserts write_enb[addr], increments 6-bit count; after len-th byte next PARITY.
REQ-021 PARITY: busy = fifo_full[addr]; accept writes parity byte to FIFO, next CHECK.
REQ-022 CHECK: one cycle, busy=1; err<=1 for one cycle if XOR(header, payload bytes) != parity byte; next IDLE.
REQ-023 DROP: busy=0, write_enb=0; consumes remaining bytes on accept; after last byte next IDLE, err not asserted.
REQ-024 pkt_valid=0 mid-packet SHALL stall the FSM without error or write.
REQ-025 write_enb, lfd_state, busy SHALL be combinational from state, pkt_valid, fifo_full; at most one write_enb bit high.
REQ-026 Per output i, a counter SHALL count cycles with vld_out[i]=1 and read_enb[i]=0; clear on read_enb[i]=1 or fifo_empty[i]=1.
REQ-027 Counter reaching TIMEOUT-1 SHALL register soft_reset[i]=1 for exactly one cycle and clear the counter.
REQ-028 soft_reset[addr] during PAYLOAD/PARITY SHALL abort the packet: next DROP for remaining bytes incl. parity, no err.
REQ-029 Timeouts on different outputs SHALL be independent and may pulse simultaneously.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, count=0, parity accumulator=0, all timeout counters 0, soft_reset=0, err=0.
REQ-031 While reset=1, write_enb=0, lfd_state=0, busy=0; reset mid-packet discards the packet.

Verification
REQ-032 Header 8'h11, 4 payload bytes, correct parity, fifo_full=0 -> write_enb=3'b010 for 6 cycles, lfd_state=1 only first, err=0.
REQ-033 Same packet with wrong parity -> 6 writes to FIFO 1, err=1 exactly one cycle after parity accept.
REQ-034 fifo_full[1]=1 for 3 cycles mid-payload -> busy=1 those cycles, no write, packet resumes, total writes 6.
REQ-035 Header 8'h0B (len 2, addr 3) + 3 bytes -> write_enb=0 throughout, busy=0, back to IDLE, err=0.
REQ-036 fifo_empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0]=1 on 30th cycle only; read_enb[0] pulse at cycle 20 -> no soft_reset.
REQ-037 reset=1 during payload byte 2 of header 8'h12 -> next cycle IDLE, all outputs 0, new header accepted immediately.
